// File: rtl/ula_mc_if.sv
// Handshake and data bundle between an ALU requester (master) and ula_mc (slave).
// The master drives the request and the operands. The slave returns status and the registered result.
interface ula_mc_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [2:0]       op;
  logic             sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             v;
  logic             dz;

  modport master (
    output start, op, sign, a, b,
    input  busy, done, result, v, dz
  );

  modport slave (
    input  start, op, sign, a, b,
    output busy, done, result, v, dz
  );
endinterface

// File: rtl/ula_mc.sv
// Multi-cycle ALU: 1-cycle SUB/ADD/EQU/SLT, WIDTH-iteration shift-add MUL and restoring DIV/REM.
// Define ULA_MC_DIV_EN to build the divider; without it DIV/REM complete as the reserved opcode.
module ula_mc #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input logic    clock,
  input logic    reset,
  ula_mc_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [2:0] OP_SUB = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_EQU = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_REM = 3'b110;

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [2:0]       op_r;
  logic             sign_r;
  logic [CNT_W-1:0] cnt;
  // hi/lo hold the product (MUL) or remainder/quotient (DIV/REM) while iterating.
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  logic             multi_op;
  logic [WIDTH-1:0] addsub_b;
  logic [WIDTH-1:0] addsub_res;
  logic             addsub_v;
  logic             lt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] res_n;
  logic             v_n;
  logic             dz_n;
`ifdef ULA_MC_DIV_EN
  logic [WIDTH:0]   div_trial;
`endif

  // Only the iterative ops with usable operands go through CALC.
  always_comb begin
    multi_op = (bus.op == OP_MUL);
`ifdef ULA_MC_DIV_EN
    if ((bus.op == OP_DIV || bus.op == OP_REM) && bus.b != '0)
      multi_op = 1'b1;
`endif
  end

  always_comb begin
    addsub_b   = (op_r == OP_SUB) ? (~b_r + ONE) : b_r;
    addsub_res = a_r + addsub_b;
    addsub_v   = (a_r[WIDTH-1] == addsub_b[WIDTH-1]) &&
                 (addsub_res[WIDTH-1] != a_r[WIDTH-1]);
    lt         = sign_r ? ($signed(a_r) < $signed(b_r)) : (a_r < b_r);
    mul_sum    = {1'b0, hi} + (lo[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
  end

`ifdef ULA_MC_DIV_EN
  // A set top bit means the trial subtraction borrowed, so the partial remainder is kept.
  assign div_trial = {hi, lo[WIDTH-1]} - {1'b0, b_r};
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    res_n = '0;
    v_n   = 1'b0;
    dz_n  = 1'b0;
    case (op_r)
      OP_SUB, OP_ADD: begin
        res_n = addsub_res;
        v_n   = addsub_v;
      end
      OP_EQU: res_n = {{(WIDTH-1){1'b0}}, (a_r == b_r)};
      OP_SLT: res_n = {{(WIDTH-1){1'b0}}, lt};
      OP_MUL: begin
        res_n = lo;
        v_n   = |hi;
      end
`ifdef ULA_MC_DIV_EN
      OP_DIV: begin
        dz_n  = (b_r == '0);
        res_n = dz_n ? '1 : lo;
      end
      OP_REM: begin
        dz_n  = (b_r == '0);
        res_n = dz_n ? a_r : hi;
      end
`endif
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: every register is plain flop state (no RAM), so all of it is cleared on reset.
    if (reset) begin
      state      <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      op_r       <= '0;
      sign_r     <= 1'b0;
      cnt        <= '0;
      hi         <= '0;
      lo         <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.v      <= 1'b0;
      bus.dz     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_r      <= bus.a;
            b_r      <= bus.b;
            op_r     <= bus.op;
            sign_r   <= bus.sign;
            cnt      <= '0;
            hi       <= '0;
            lo       <= (bus.op == OP_MUL) ? bus.b : bus.a;
            bus.busy <= 1'b1;
            state    <= multi_op ? CALC : DONE;
          end
        end
        CALC: begin
          if (op_r == OP_MUL) begin
            hi <= mul_sum[WIDTH:1];
            lo <= {mul_sum[0], lo[WIDTH-1:1]};
          end
`ifdef ULA_MC_DIV_EN
          else if (!div_trial[WIDTH]) begin
            hi <= div_trial[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], 1'b1};
          end else begin
            hi <= {hi[WIDTH-2:0], lo[WIDTH-1]};
            lo <= {lo[WIDTH-2:0], 1'b0};
          end
`endif
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_LAST)
            state <= DONE;
        end
        DONE: begin
          bus.done   <= 1'b1;
          bus.busy   <= 1'b0;
          bus.result <= res_n;
          bus.v      <= v_n;
          bus.dz     <= dz_n;
          state      <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_mc.sv
// Randomized, self-checking bench for ula_mc at WIDTH=8, using an arithmetic reference model.
// DIV/REM expectations follow whether ULA_MC_DIV_EN is defined for the build.
module tb_ula_mc;
  localparam int W = 8;

  typedef struct packed {
    logic [2:0] op;
    logic       sg;
    logic [7:0] a;
    logic [7:0] b;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  ula_mc_if #(.WIDTH(W)) bus();
  ula_mc #(.WIDTH(W), .CNT_W(7)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  // Reference model: the expected outcome of one operation, worked out with plain arithmetic.
  function automatic void model(input logic [2:0] op, input logic sg, input logic [7:0] a,
                                input logic [7:0] b, output logic [7:0] r, output logic ov,
                                output logic dzo, output int lat);
    logic [7:0]  nb;
    int unsigned p;
    r = 8'h00; ov = 1'b0; dzo = 1'b0; lat = 1;
    case (op)
      3'd0: begin
        r  = a - b;
        nb = 8'h00 - b;
        ov = (a[7] == nb[7]) && (r[7] != a[7]);
      end
      3'd1: begin
        r  = a + b;
        ov = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd2: r = (a == b) ? 8'd1 : 8'd0;
      3'd3: begin
        if (sg) r = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
        else    r = (a < b) ? 8'd1 : 8'd0;
      end
      3'd4: begin
        p   = int'(a) * int'(b);
        r   = p[7:0];
        ov  = (p > 255);
        lat = W + 1;
      end
`ifdef ULA_MC_DIV_EN
      3'd5, 3'd6: begin
        if (b == 8'h00) begin
          dzo = 1'b1;
          r   = (op == 3'd5) ? 8'hFF : a;
        end else begin
          r   = (op == 3'd5) ? a / b : a % b;
          lat = W + 1;
        end
      end
`endif
      default: ;
    endcase
  endfunction

  // Issues one request, scrambles the operand inputs after capture and waits (bounded) for done.
  task automatic do_op(input logic [2:0] op, input logic sg, input logic [7:0] a, input logic [7:0] b,
                       input bit noise, output int lat, output logic [7:0] r, output logic ov,
                       output logic dzo, output int busy_low);
    @(negedge clock);
    bus.start = 1'b1; bus.op = op; bus.sign = sg; bus.a = a; bus.b = b;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    bus.op = 3'($urandom); bus.sign = 1'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
    lat = 0;
    busy_low = 0;
    while (lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
      if (bus.done) break;
      if (!bus.busy) busy_low++;
      if (noise) begin
        bus.start = 1'b1; bus.op = 3'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
      end
    end
    bus.start = 1'b0;
    r = bus.result; ov = bus.v; dzo = bus.dz;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({bus.busy, bus.done, bus.result, bus.v, bus.dz} !== 12'h000)
      $display("FAIL reset_outputs: busy=%b done=%b result=%h v=%b dz=%b, required all 0",
               bus.busy, bus.done, bus.result, bus.v, bus.dz);
    else pass_cnt++;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    total_cnt++;
    if ({bus.busy, bus.done} !== 2'b00)
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", bus.busy, bus.done);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    vec_t vecs [16];
    logic [7:0] r, er;
    logic ov, ev, dzo, edz;
    int lat, elat, bl;
    vecs = '{
      '{3'd1, 1'b0, 8'h7F, 8'h01}, '{3'd0, 1'b0, 8'h80, 8'h01},
      '{3'd3, 1'b1, 8'hFF, 8'h01}, '{3'd3, 1'b0, 8'hFF, 8'h01},
      '{3'd2, 1'b0, 8'h5A, 8'h5A}, '{3'd2, 1'b0, 8'h5A, 8'h5B},
      '{3'd4, 1'b0, 8'h10, 8'h10}, '{3'd4, 1'b0, 8'h0C, 8'h0B},
      '{3'd5, 1'b0, 8'hC8, 8'h07}, '{3'd6, 1'b0, 8'hC8, 8'h07},
      '{3'd5, 1'b0, 8'hC8, 8'h00}, '{3'd6, 1'b0, 8'hC8, 8'h00},
      '{3'd7, 1'b1, 8'h12, 8'h34}, '{3'd0, 1'b0, 8'h00, 8'h80},
      '{3'd4, 1'b0, 8'hFF, 8'hFF}, '{3'd5, 1'b0, 8'h07, 8'hC8}
    };
    foreach (vecs[i]) begin
      model(vecs[i].op, vecs[i].sg, vecs[i].a, vecs[i].b, er, ev, edz, elat);
      do_op(vecs[i].op, vecs[i].sg, vecs[i].a, vecs[i].b, 1'b0, lat, r, ov, dzo, bl);
      total_cnt++;
      if ({r, ov, dzo} !== {er, ev, edz})
        $display("FAIL directed_%0d op=%0d: result=%h v=%b dz=%b, required result=%h v=%b dz=%b",
                 i, vecs[i].op, r, ov, dzo, er, ev, edz);
      else pass_cnt++;
      total_cnt++;
      if (lat != elat || bl != 0)
        $display("FAIL directed_latency_%0d op=%0d: latency=%0d busy_low=%0d, required latency=%0d busy_low=0",
                 i, vecs[i].op, lat, bl, elat);
      else pass_cnt++;
    end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] r, er;
    logic ov, ev, dzo, edz;
    int lat, elat, bl;
    for (int i = 0; i < 6; i++) begin
      logic [2:0] op;
      logic [7:0] a, b;
      op = (i % 2 == 0) ? 3'd4 : 3'(5 + (i % 4) / 2);
      a = 8'($urandom); b = 8'($urandom_range(1, 255));
      model(op, 1'b0, a, b, er, ev, edz, elat);
      do_op(op, 1'b0, a, b, 1'b1, lat, r, ov, dzo, bl);
      total_cnt++;
      if ({r, ov, dzo} !== {er, ev, edz} || lat != elat || bl != 0)
        $display("FAIL busy_ignore_%0d op=%0d: result=%h v=%b dz=%b lat=%0d busy_low=%0d, required %h %b %b %0d 0",
                 i, op, r, ov, dzo, lat, bl, er, ev, edz, elat);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold();
    logic [7:0] r;
    logic ov, dzo;
    int lat, bl;
    do_op(3'd1, 1'b0, 8'h33, 8'h44, 1'b0, lat, r, ov, dzo, bl);
    repeat (3) @(posedge clock);
    #1;
    total_cnt++;
    if ({bus.done, bus.busy, bus.result, bus.v} !== {2'b00, 8'h77, 1'b0})
      $display("FAIL result_hold: done=%b busy=%b result=%h v=%b, required done=0 busy=0 result=77 v=0",
               bus.done, bus.busy, bus.result, bus.v);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    logic [7:0] r;
    logic ov, dzo;
    int lat, bl, seen;
    @(negedge clock);
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 8'h0C; bus.b = 8'h0B;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({bus.busy, bus.done, bus.result, bus.v, bus.dz} !== 12'h000)
      $display("FAIL abort_outputs: busy=%b done=%b result=%h v=%b dz=%b, required all 0",
               bus.busy, bus.done, bus.result, bus.v, bus.dz);
    else pass_cnt++;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clock);
      #1;
      if (bus.done || bus.busy) seen++;
    end
    total_cnt++;
    if (seen != 0)
      $display("FAIL abort_no_done: %0d cycles with done/busy high, required 0", seen);
    else pass_cnt++;
    do_op(3'd1, 1'b0, 8'h01, 8'h02, 1'b0, lat, r, ov, dzo, bl);
    total_cnt++;
    if (r !== 8'h03 || lat != 1)
      $display("FAIL add_after_abort: result=%h latency=%0d, required result=03 latency=1", r, lat);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [7:0] r, er;
    logic ov, ev, dzo, edz;
    int lat, elat, bl;
    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      logic sg;
      logic [7:0] a, b;
      op = 3'($urandom); sg = 1'($urandom); a = 8'($urandom);
      b = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      model(op, sg, a, b, er, ev, edz, elat);
      do_op(op, sg, a, b, 1'($urandom), lat, r, ov, dzo, bl);
      total_cnt++;
      if ({r, ov, dzo} !== {er, ev, edz} || lat != elat || bl != 0)
        $display("FAIL random_%0d op=%0d sign=%b a=%h b=%h: result=%h v=%b dz=%b lat=%0d busy_low=%0d, required %h %b %b %0d 0",
                 i, op, sg, a, b, r, ov, dzo, lat, bl, er, ev, edz, elat);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r, er;
    logic ov, ev, dzo, edz;
    int lat, elat, bl;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] op;
      logic [7:0] a, b;
      op = 3'(i % 4); a = 8'($urandom); b = 8'($urandom);
      model(op, 1'b1, a, b, er, ev, edz, elat);
      do_op(op, 1'b1, a, b, 1'b0, lat, r, ov, dzo, bl);
      total_cnt++;
      if ({r, ov, dzo} !== {er, ev, edz} || lat != elat)
        $display("FAIL back_to_back_%0d op=%0d: result=%h v=%b dz=%b lat=%0d, required %h %b %b %0d",
                 i, op, r, ov, dzo, lat, er, ev, edz, elat);
      else pass_cnt++;
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 3'd0; bus.sign = 1'b0; bus.a = 8'h00; bus.b = 8'h00;
    test_reset();
    test_directed();
    test_busy_ignore();
    test_hold();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ula_mc.md
ULA_MC -- requirements
Module: ula_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width in bits (legal range 4..64).
REQ-002 SHALL have parameter CNT_W, default 7, iteration counter width; SHALL satisfy 2**CNT_W > WIDTH.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request; sampled only in IDLE.
REQ-006 op  in  3  operation code: 000 SUB, 001 ADD, 010 EQU, 011 SLT, 100 MUL, 101 DIV, 110 REM, 111 reserved.
REQ-007 sign  in  1  SLT comparison mode: 1 signed, 0 unsigned.
REQ-008 a, b  in  WIDTH  operands, two's complement.
REQ-009 busy  out  1  high whenever FSM is not IDLE.
REQ-010 done  out  1  single-cycle completion pulse.
REQ-011 result  out  WIDTH  registered result, held until the next completion.
REQ-012 v  out  1  registered overflow flag.
REQ-013 dz  out  1  registered divide-by-zero flag.

Function
REQ-014 FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-015 IDLE with start=1: SHALL capture a, b, op and sign into internal registers; next state DONE for SUB/ADD/EQU/SLT/111, CALC for MUL/DIV/REM.
REQ-016 start SHALL be ignored in CALC and DONE; operand changes after capture SHALL NOT affect the result.
REQ-017 CALC SHALL run exactly WIDTH iterations, one per clock, then go to DONE.
REQ-018 DONE SHALL assert done for one cycle, update result/v/dz in that same cycle, and return to IDLE.
REQ-019 Latency from the start edge to done SHALL be 1 cycle for single-cycle ops and WIDTH+1 cycles for MUL/DIV/REM.
REQ-020 SUB/ADD SHALL produce a-b and a+b modulo 2**WIDTH; v SHALL be set on signed overflow (operand signs, after negating b for SUB, are equal and the result sign differs).
REQ-021 EQU SHALL produce 1 if a==b, else 0; v=0.
REQ-022 SLT SHALL produce 1 if a<b (signed when sign=1, unsigned when sign=0), else 0; v=0.
REQ-023 MUL SHALL be an unsigned shift-add; result = low WIDTH bits of the product; v=1 if the high WIDTH bits are non-zero.
REQ-024 DIV/REM SHALL be unsigned restoring division; result = quotient (DIV) or remainder (REM); v=0.
REQ-025 b==0 with DIV/REM SHALL skip CALC and go directly to DONE: dz=1, result all ones (DIV) or a (REM).
REQ-026 op 111 SHALL produce result 0, v=0, dz=0.
REQ-027 dz SHALL be 0 for every completion other than REQ-025.

Reset
REQ-028 reset SHALL force state IDLE, busy=0, done=0, result=0, v=0, dz=0 and clear all internal registers, independent of clock.
REQ-029 reset during CALC or DONE SHALL abort the operation with no done pulse; the first rising edge after reset deasserts SHALL behave as IDLE.

Configuration
REQ-030 Macro ULA_MC_DIV_EN SHALL gate the divider.
- Defined: DIV/REM behave per REQ-024/025.
- Undefined: DIV/REM SHALL behave as op 111 (1-cycle latency, result 0, v=0, dz=0), and no divider logic is instantiated.

Verification (WIDTH=8, ULA_MC_DIV_EN defined unless stated)
REQ-031 ADD a=0x7F, b=0x01, start pulse -> done 1 cycle later, result=0x80, v=1; SUB a=0x80, b=0x01 -> result=0x7F, v=1.
REQ-032 SLT a=0xFF, b=0x01, sign=1 -> result=1; same operands with sign=0 -> result=0; EQU a=b=0x5A -> result=1.
REQ-033 MUL a=0x10, b=0x10 -> done 9 cycles after start, result=0x00, v=1; MUL a=0x0C, b=0x0B -> result=0x84, v=0; start pulses during busy are ignored.
REQ-034 DIV a=0xC8, b=0x07 -> result=0x1C after 9 cycles; REM -> result=0x04; DIV b=0 -> done after 1 cycle, result=0xFF, dz=1.
REQ-035 Start MUL, assert reset at cycle 4 -> outputs all 0, no done pulse; ADD a=0x01, b=0x02 after reset -> result=0x03 after 1 cycle.
REQ-036 ULA_MC_DIV_EN undefined: DIV a=0xC8, b=0x07 -> done after 1 cycle, result=0x00, dz=0.
